instruction_fetch: RTL



---
 rtl/riscv_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 88 ++++++++
 rtl/instruction_fetch.sv | 126 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: state encoding, word sizes and the NOP encoding.
package riscv_pkg;

  localparam int          INST_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  // S_FETCH: idle, may issue; S_WAIT: one request outstanding;
  // S_DRAIN: outstanding response will be thrown away; S_HALT: stopped on bad target.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small {pc, inst} buffer between fetch and decode. Flush wins over push and pop.
// Storage is cleared only by reset so the head outputs read zero out of reset.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [31:0]       push_pc,
  input  logic [INST_W-1:0] push_inst,
  output logic              head_valid,
  output logic [31:0]       head_pc,
  output logic [INST_W-1:0] head_inst,
  output logic [CW-1:0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]       pc_q   [DEPTH];
  logic [31:0]       pc_d   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [INST_W-1:0] inst_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_en, pop_en;

  assign pop_en  = pop && (count_q != '0) && !flush;
  assign push_en = push && !flush && ((count_q != CW'(DEPTH)) || pop_en);

  assign head_valid = (count_q != '0);
  assign head_pc    = pc_q[rd_ptr_q];
  assign head_inst  = inst_q[rd_ptr_q];
  assign count      = count_q;

  // Next storage, pointers and occupancy from push/pop/flush.
  always_comb begin
    pc_d     = pc_q;
    inst_d   = inst_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        pc_d[wr_ptr_q]   = push_pc;
        inst_d[wr_ptr_q] = push_inst;
        wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO registers; reset also clears the storage words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: holds the PC, keeps at most one memory request in flight,
// buffers returned words in fetch_fifo and hands them to decode.
// Optional: define IFETCH_ALIGN_CHECK_EN to trap misaligned redirect targets
// (sticky misalign_err, fetch halts until reset). Without it the target's low
// two bits are cleared and misalign_err stays 0.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_valid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [31:0]       inst_pc,
  output logic              misalign_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] fifo_count;
  logic          fifo_room;
  logic          redir_take;
  logic          redir_bad;
  logic [31:0]   redir_target;
  logic          push;
  logic          pop;

  assign redir_take = redirect_valid && (state_q != S_HALT);
  assign fifo_room  = (fifo_count < CW'(DEPTH));

`ifdef IFETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign redir_bad    = redir_take && (redirect_pc[1:0] != 2'b00);
  assign redir_target = redirect_pc;
  assign misalign_err = misalign_q;

  // Sticky flag, cleared only by reset.
  always_comb begin
    misalign_d = misalign_q | redir_bad;
  end

  // Misalign flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
`else
  assign redir_bad    = 1'b0;
  assign redir_target = redirect_pc & ~32'h0000_0003;
  assign misalign_err = 1'b0;
`endif

  // State and PC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Next state: redirect first, then request issue / response arrival.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (redir_take)    state_d = redir_bad ? S_HALT : S_FETCH;
        else if (imem_req) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redir_take)      state_d = redir_bad ? S_HALT : (imem_valid ? S_FETCH : S_DRAIN);
        else if (imem_valid) state_d = S_FETCH;
      end
      S_DRAIN: begin
        // A response arriving together with a redirect still retires the
        // outstanding request, so there is nothing left to drain.
        if (redir_take && redir_bad) state_d = S_HALT;
        else if (imem_valid)         state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs and datapath controls: request, FIFO push/pop, next fetch PC.
  always_comb begin
    imem_req   = (state_q == S_FETCH) && fifo_room && !redirect_valid && !reset;
    imem_addr  = fetch_pc_q;
    push       = (state_q == S_WAIT) && imem_valid && !redir_take;
    pop        = inst_valid && inst_ready;
    fetch_pc_d = fetch_pc_q;
    if (redir_take && !redir_bad) fetch_pc_d = redir_target;
    else if (push)                fetch_pc_d = fetch_pc_q + PC_STEP;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redir_take),
    .push_pc    (fetch_pc_q),
    .push_inst  (imem_rdata),
    .head_valid (inst_valid),
    .head_pc    (inst_pc),
    .head_inst  (inst_out),
    .count      (fifo_count)
  );

endmodule
